// File: rtl/register_read_arbiter.sv
// Round-robin sequencer serialising NUM_REQ requesters onto one register read port.
// Define READ_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with an error response.
module register_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 rd,
  output logic [1:0]           rd_addr,
  input  logic [31:0]          rd_data,
  input  logic                 rd_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      last_gnt;
  logic [IW-1:0]      pick_idx;
  logic [1:0]         pick_addr;
  logic               pick_found;
  logic               take;
  logic               finish_ok;
  logic               finish_tmo;
  logic               tmo_hit;
  logic [NUM_REQ-1:0] sel;

  // Search starts just after the last served requester.
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      c = int'(last_gnt) + 1 + p;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!pick_found && req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
        pick_addr  = req_addr[2*c +: 2];
      end
    end
  end

`ifdef READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign tmo_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= finish_tmo;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !rd_done && !tmo_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    take       = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          take    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // A completion in the timeout cycle still wins.
        if (rd_done) begin
          finish_ok = 1'b1;
          state_n   = IDLE;
        end else if (tmo_hit) begin
          finish_tmo = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel  = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  assign busy = (state != IDLE);
  assign rd   = (state == ISSUE);
  assign gnt  = busy ? sel : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      last_gnt  <= IW'(NUM_REQ - 1);
      rd_addr   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= '0;
      if (take) begin
        idx     <= pick_idx;
        rd_addr <= pick_addr;
      end
      if (finish_ok || finish_tmo) begin
        rsp_valid <= sel;
        rsp_data  <= finish_ok ? rd_data : '0;
        last_gnt  <= idx;
      end
    end
  end

endmodule

// File: tb/tb_register_read_arbiter.sv
// Scoreboard bench for register_read_arbiter: transaction-level model predicts
// grant order, rd strobes and responses; monitors compare at the falling edge.
`timescale 1ns/1ps
module tb_register_read_arbiter;

  localparam int N   = 3;
  localparam int AW  = 2 * N;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          rd;
  logic [1:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          rd_done;

  register_read_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_addr(req_addr),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy),
    .rd(rd),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         idx;
    logic [1:0] addr;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
    logic        err;
  } rsp_exp_t;

  typedef struct {
    logic [N-1:0]  r;
    logic [AW-1:0] a;
  } ovr_t;

  rd_exp_t  exp_rd[$];
  rsp_exp_t exp_rsp[$];
  ovr_t     ovr_q[$];
  int       force_q[$];

  logic [31:0] regs [4];
  logic [31:0] hold_data = '0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode = 3;
  int   next_free = 0;
  int   issue_cyc = -10;
  int   win_s = -10;
  int   win_e = -10;
  int   last = N - 1;
  bit   mon_en = 0;
  bit   chk_zero = 0;
  bit   post_rst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic rst_in);
    ovr_t       o;
    int         d;
    int         h;
    int         w;
    logic [1:0] a;
    logic       exp_busy;
    @(posedge clk);
    #1;
    exp_busy = (cyc >= issue_cyc) && (cyc < next_free);
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
    end
    if (chk_zero) begin
      chk_zero  = 0;
      hold_data = '0;
      checks++;
      if ({gnt, rsp_valid, rsp_err, busy, rd, rd_addr, rsp_data} !== '0) begin
        errors++;
        $display("FAIL reset_vals cyc=%0d got gnt=%b v=%b e=%b b=%b rd=%b ra=%0d d=%h want all 0",
                 cyc, gnt, rsp_valid, rsp_err, busy, rd, rd_addr, rsp_data);
      end
    end
    if (ovr_q.size() != 0) begin
      o        = ovr_q.pop_front();
      req      = o.r;
      req_addr = o.a;
    end else begin
      req_addr = AW'($urandom);
      case (mode)
        0: for (int i = 0; i < N; i++)
             if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        1: req = '1;
        2: req = N'(1);
        default: req = '0;
      endcase
    end
    reset = rst_in;
    if (rst_in) begin
      rd_done = 1'b0;
      rd_data = $urandom;
    end else if (post_rst) begin
      post_rst = 0;
      rd_done  = 1'b1;
      rd_data  = $urandom;
    end else if (cyc >= win_s && cyc <= win_e) begin
      rd_done = 1'b1;
      rd_data = regs[rd_addr];
    end else begin
      rd_data = $urandom;
      rd_done = (cyc == next_free || cyc == issue_cyc) &&
                ($urandom_range(0, 3) == 0);
    end
    if (rst_in) begin
      next_free = cyc + 1;
      issue_cyc = -10;
      win_s     = -10;
      win_e     = -10;
      last      = N - 1;
      chk_zero  = 1;
      post_rst  = 1;
      exp_rd.delete();
      exp_rsp.delete();
    end else if (cyc == next_free) begin
      if (req == '0) begin
        next_free = cyc + 1;
      end else begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(last + k) % N]) w = (last + k) % N;
        a = req_addr[2*w +: 2];
        if (force_q.size() != 0) d = force_q.pop_front();
        else if (mode == 2) d = 0;
        else d = $urandom_range(0, 3);
        h = $urandom_range(1, 3);
        exp_rd.push_back('{cyc + 1, w, a});
        issue_cyc = cyc + 1;
        last      = w;
`ifdef READ_TIMEOUT_EN
        if (d >= TMO) begin
          win_s     = -10;
          win_e     = -10;
          next_free = cyc + 2 + TMO;
          exp_rsp.push_back('{next_free, w, 32'h0, 1'b1});
        end else
`endif
        begin
          win_s     = cyc + 2 + d;
          win_e     = win_s + h - 1;
          next_free = cyc + 3 + d;
          exp_rsp.push_back('{next_free, w, regs[a], 1'b0});
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic go_idle();
    int  saved;
    bit  ok;
    saved = mode;
    mode  = 3;
    ok    = 0;
    for (int k = 0; k < 200; k++) begin
      drive(1'b0);
      if (next_free == cyc + 1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_bound cyc=%0d got busy=%b want idle within 200 cycles", cyc, busy);
    end
    mode = saved;
  endtask

  always @(negedge clk) begin
    rd_exp_t     re;
    rsp_exp_t    pe;
    logic [N-1:0] one;
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || !$onehot0(rsp_valid)) begin
        errors++;
        $display("FAIL onehot cyc=%0d got gnt=%b rsp_valid=%b want zero or one-hot",
                 cyc, gnt, rsp_valid);
      end
      while (exp_rd.size() != 0 && exp_rd[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL rd_missing cyc=%0d got none want rd at %0d idx %0d",
                 cyc, exp_rd[0].cyc, exp_rd[0].idx);
        void'(exp_rd.pop_front());
      end
      while (exp_rsp.size() != 0 && exp_rsp[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing cyc=%0d got none want rsp at %0d idx %0d",
                 cyc, exp_rsp[0].cyc, exp_rsp[0].idx);
        void'(exp_rsp.pop_front());
      end
      if (rd) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected cyc=%0d got rd addr %0d want no rd", cyc, rd_addr);
        end else begin
          re = exp_rd.pop_front();
          one = '0;
          one[re.idx] = 1'b1;
          if (re.cyc != cyc || rd_addr !== re.addr || gnt !== one) begin
            errors++;
            $display("FAIL rd cyc=%0d got addr %0d gnt %b want cyc %0d addr %0d gnt %b",
                     cyc, rd_addr, gnt, re.cyc, re.addr, one);
          end
        end
      end
      if (rsp_valid != '0) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected cyc=%0d got v=%b d=%h want none", cyc, rsp_valid, rsp_data);
        end else begin
          pe = exp_rsp.pop_front();
          one = '0;
          one[pe.idx] = 1'b1;
          hold_data = pe.data;
          if (pe.cyc != cyc || rsp_valid !== one || rsp_data !== pe.data || rsp_err !== pe.err) begin
            errors++;
            $display("FAIL rsp cyc=%0d got v=%b d=%h e=%b want cyc %0d v=%b d=%h e=%b",
                     cyc, rsp_valid, rsp_data, rsp_err, pe.cyc, one, pe.data, pe.err);
          end
        end
      end else begin
        checks++;
        if (rsp_data !== hold_data || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL rsp_hold cyc=%0d got d=%h e=%b want d=%h e=0",
                   cyc, rsp_data, rsp_err, hold_data);
        end
      end
    end
  end

  initial begin
    regs[0]  = 32'h0000_0011;
    regs[1]  = $urandom;
    regs[2]  = 32'h0000_00A5;
    regs[3]  = 32'h0000_0033;
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    rd_done  = 1'b0;
    rd_data  = '0;

    drive(1'b1);
    mon_en = 1;
    drive(1'b1);
    drive(1'b1);

    // single read of register 2 by requester 0
    ovr_q.push_back('{N'(1), AW'(2)});
    force_q.push_back(0);
    run(6);

    // all requesters held: strict rotation
    mode = 1;
    run(40);

    // lone requester back to back
    go_idle();
    mode = 2;
    run(30);

    // req[1] pulsed only during requester 0's ISSUE
    mode = 3;
    go_idle();
    ovr_q.push_back('{N'(1), AW'(1)});
    ovr_q.push_back('{N'(2), AW'(12)});
    run(8);

    // reset in WAIT, then late rd_done
    go_idle();
    ovr_q.push_back('{N'(2), AW'(12)});
    force_q.push_back(6);
    run(3);
    drive(1'b1);
    ovr_q.push_back('{N'(0), AW'(0)});
    ovr_q.push_back('{N'(2), AW'(4)});
    run(8);
    go_idle();
    drive(1'b1);
    ovr_q.push_back('{N'(7), AW'(6'b110100)});
    run(8);

    // stalled register port
    go_idle();
    ovr_q.push_back('{N'(1), AW'(3)});
`ifdef READ_TIMEOUT_EN
    force_q.push_back(TMO + 3);
    run(2);
    go_idle();
    ovr_q.push_back('{N'(1), AW'(2)});
    force_q.push_back(TMO - 1);
    run(2);
    go_idle();
    ovr_q.push_back('{N'(1), AW'(0)});
    force_q.push_back(0);
    run(4);
`else
    force_q.push_back(40);
    run(46);
`endif

    // random traffic
    go_idle();
    mode = 0;
    run(2000);
    mode = 3;
    go_idle();
    run(6);

    checks++;
    if (exp_rd.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL drain got rd %0d rsp %0d outstanding want 0 0",
               exp_rd.size(), exp_rsp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_read_arbiter.md
Name: register_read_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4-entry button/control register read port.
- Accepts read requests from NUM_REQ independent requesters (e.g. HPS bridge, game logic).
- Serialises them onto the single rd/rd_addr/rd_data/rd_done port.
- Returns each result to the requester that issued it.
- Sits between the requesters and the register read block in the button-control subsystem.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 16, WAIT-state cycles before a read is aborted (used only with READ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester read request, level
req_addr  in  2*NUM_REQ  flattened register index; bits [2i+1:2i] belong to requester i
gnt  out  NUM_REQ  one-hot; high for the granted requester during ISSUE and WAIT
rsp_valid  out  NUM_REQ  one-cycle pulse to the requester whose read completed
rsp_data  out  32  read result; held until the next response
rsp_err  out  1  high with rsp_valid when the read timed out
busy  out  1  high in ISSUE and WAIT
rd  out  1  read strobe to the register port
rd_addr  out  2  register index to the register port
rd_data  in  32  data from the register port
rd_done  in  1  completion from the register port

Behaviour:
Reset values:
- state=IDLE; gnt, rsp_valid, rsp_err, busy, rd = 0.
- rd_addr=0, rsp_data=0.
- last_gnt=NUM_REQ-1, so requester 0 wins first.

States IDLE, ISSUE, WAIT:
- IDLE: if any req bit is set, grant the first set bit searching from last_gnt+1 modulo NUM_REQ upward. Latch the index and its req_addr, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: one cycle; rd=1, rd_addr=latched addr; go to WAIT.
- WAIT: rd=0, rd_addr held. When rd_done=1, register rd_data into rsp_data, pulse rsp_valid[idx] next cycle, set last_gnt=idx, and return to IDLE.

Timing and handshake:
- rsp_valid, rsp_data and rsp_err are registered.
- Latency with a 1-cycle port: req seen in cycle 0, rd high in cycle 1, rd_done in cycle 2, rsp_valid in cycle 3.
- A new grant can be made in cycle 3. The cycle-3 response pulse and a new ISSUE overlap legally.
- A requester holds req until it sees rsp_valid.
- Dropping req before it is sampled in IDLE withdraws it.
- After latching, the transaction completes even if req drops. Addr changes after latching are ignored.
- req still high in the cycle after rsp_valid counts as a new request, and it has lowest priority.

Boundary conditions:
- rd_done while in IDLE or ISSUE: ignored.
- rd_done held high for several cycles: only the first cycle in WAIT counts.
- Simultaneous requests: strict round-robin, so no requester is granted twice while another is waiting.
- Single active requester: granted back-to-back without penalty.
- Reset in any state: immediate return to reset values, in-flight read discarded, no rsp_valid issued.
- gnt is always zero or one-hot. rsp_valid is always zero or one-hot.

Optional Feature:
Macro READ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without rd_done.
  - At TIMEOUT_CYCLES it forces a return to IDLE, with rsp_valid[idx]=1, rsp_err=1, rsp_data=0, and last_gnt updated.
  - rd_done arriving in the same cycle as the timeout takes precedence: normal response, rsp_err=0.
- Undefined: WAIT lasts until rd_done with no bound; rsp_err is tied to 0; no counter is present.

Test Plan:
1. Register 2=0x0000_00A5; req[0]=1, addr0=2 in cycle 0 -> gnt[0]=1 and rd=1 with rd_addr=2 in cycle 1; rsp_valid[0]=1, rsp_data=0x0000_00A5, rsp_err=0 in cycle 3.
2. NUM_REQ=2, req=2'b11 held, addr0=0, addr1=3, reg0=0x11, reg3=0x33 -> grant order 0,1,0,1; rsp_data alternates 0x11/0x33; each rsp_valid one-hot.
3. Reset asserted for one cycle while in WAIT, then rd_done=1 -> all outputs 0; no rsp_valid; next req[1] alone is granted normally; after reset, req=2'b11 grants requester 0 first.
4. req[1] pulsed only while in ISSUE serving requester 0, then low -> no rd issued for requester 1; busy=0 after the response.
5. With READ_TIMEOUT_EN, TIMEOUT_CYCLES=8, rd_done stuck 0 -> rsp_valid[0]=1, rsp_err=1, rsp_data=0 after 8 WAIT cycles; subsequent reads succeed. Without the macro, busy stays 1 indefinitely.
6. req[0] held continuously, others idle -> a new rd every 3 cycles; rd_done held high for 3 cycles yields exactly one response per read.
